// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at acceptance without iterating.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] resp_data_reg;
    logic             is_rem_reg;
    logic             neg_quo_reg;
    logic             neg_rem_reg;

    // Acceptance-time decode
    logic             is_signed;
    logic             is_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_by_zero;
    logic             overflow;
    logic [WIDTH-1:0] special_data;
    logic             accept;

    assign is_signed    = ~div_op[0];
    assign is_rem       = div_op[1];
    assign a_neg        = is_signed & operand_a[WIDTH-1];
    assign b_neg        = is_signed & operand_b[WIDTH-1];
    assign a_mag        = a_neg ? (~operand_a + 1'b1) : operand_a;
    assign b_mag        = b_neg ? (~operand_b + 1'b1) : operand_b;
    assign div_by_zero  = (operand_b == '0);
    assign overflow     = is_signed & (operand_a == MIN_VAL) & (operand_b == '1);
    assign special_data = div_by_zero ? (is_rem ? operand_a : '1)
                                      : (is_rem ? '0 : MIN_VAL);
    assign accept       = req_valid & req_ready;

    // One restoring step; the top bit of the difference is the borrow, so it doubles as the compare
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] step_rem_next;
    logic [WIDTH-1:0] step_quo_next;
    logic [WIDTH-1:0] result_next;

    assign shifted       = {rem_reg, quo_reg[WIDTH-1]};
    assign diff          = shifted - {1'b0, divisor_reg};
    assign take          = ~diff[WIDTH];
    assign step_rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo_next = {quo_reg[WIDTH-2:0], take};
    assign result_next   = is_rem_reg ? (neg_rem_reg ? (~step_rem_next + 1'b1) : step_rem_next)
                                      : (neg_quo_reg ? (~step_quo_next + 1'b1) : step_quo_next);

    assign req_ready  = (state_reg == IDLE) & ~flush & ~rst;
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == DONE) & ~flush;
    assign resp_data  = resp_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            resp_data_reg <= '0;
            is_rem_reg    <= 1'b0;
            neg_quo_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        is_rem_reg  <= is_rem;
                        neg_quo_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        quo_reg     <= a_mag;
                        divisor_reg <= b_mag;
                        rem_reg     <= '0;
                        count_reg   <= '0;
                        if (div_by_zero | overflow) begin
                            resp_data_reg <= special_data;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg   <= step_rem_next;
                    quo_reg   <= step_quo_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST_CNT) begin
                        resp_data_reg <= result_next;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized scoreboard bench for div_unit: a cycle-level acceptance model predicts
// req_ready/busy and queues expected results; a monitor checks every response.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  div_op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .div_op     (div_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .flush      (flush),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   model_free = 0;
    int   last_accept = -1000;
    bit   check_on = 1'b0;
    bit   rst_at_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic flag_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s (cycle %0d)", name, cycle);
    endtask

    // Reference: plain RISC-V division semantics with 64-bit arithmetic; {special, result}
    function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] r;
        bit          special;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   r = (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            2'b01:   r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   r = (b == 32'd0) ? a : 32'(sa % sb);
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return {special, r};
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0:       t = 32'd0;
            1:       t = 32'h8000_0000;
            2:       t = 32'hFFFF_FFFF;
            3:       t = $urandom_range(0, 20);
            4: begin
                t = $urandom_range(1, 20);
                t = ~t + 32'd1;
            end
            default: t = $urandom;
        endcase
        return t;
    endfunction

    always @(posedge clk) begin
        cycle       <= cycle + 1;
        rst_at_edge <= rst;
        if (rst) check_on <= 1'b1;
    end

    // Acceptance model: predicts handshake/busy and pushes expected responses
    always @(negedge clk) begin
        bit          exp_ready;
        bit          exp_busy;
        logic [32:0] r;
        exp_t        e;
        if (check_on) begin
            exp_ready = !rst && !flush && (cycle >= model_free);
            exp_busy  = (cycle > last_accept) && (cycle < model_free);
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(exp_busy));
        end
        if (rst || flush) begin
            sb_q.delete();
            model_free = cycle + 1;
        end else if (req_valid && cycle >= model_free) begin
            r      = ref_model(div_op, operand_a, operand_b);
            e.data = r[31:0];
            e.due  = cycle + (r[32] ? 1 : 33);
            e.op   = div_op;
            e.a    = operand_a;
            e.b    = operand_b;
            sb_q.push_back(e);
            last_accept = cycle;
            model_free  = e.due + 1;
        end
    end

    // Monitor: pops and compares whenever the DUT presents a response
    always @(negedge clk) begin
        exp_t e;
        if (check_on) begin
            if (rst_at_edge) begin
                check("reset resp_data", resp_data, 32'd0);
                check("reset resp_valid", 32'(resp_valid), 32'd0);
            end
            if (resp_valid) begin
                if (flush) flag_fail("resp_valid during flush");
                if (sb_q.size() == 0) begin
                    flag_fail("unexpected resp_valid");
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] op=%0d a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) cycle %0d",
                             e.op, e.a, e.b, resp_data, e.data, cycle);
                    check("resp_data", resp_data, e.data);
                    check("resp_cycle", 32'(cycle), 32'(e.due));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due < cycle) begin
                flag_fail("missing response");
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cycle < model_free && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) flag_fail("wait_idle timeout");
    endtask

    task automatic scramble();
        div_op    = 2'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        div_op    = op;
        operand_a = a;
        operand_b = b;
        tick();
        req_valid = 1'b0;
        scramble();
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        issue(op, a, b);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed cases
        run_op(2'b00, 32'd100, 32'd7);
        run_op(2'b10, 32'd100, 32'd7);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b01, 32'h1234_5678, 32'd0);
        run_op(2'b11, 32'h1234_5678, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in CALC cycle 10, new request in cycle 11
        issue(2'b01, 32'd1000, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(2'b01, 32'd9, 32'd3);
        wait_idle();

        // Flush in the DONE cycle of a special-case op
        issue(2'b01, 32'd5, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // Flush together with a request in IDLE: nothing accepted
        flush     = 1'b1;
        req_valid = 1'b1;
        div_op    = 2'b01;
        operand_a = 32'd50;
        operand_b = 32'd5;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        tick();

        // Back-to-back with req_valid held high and operands changing each cycle
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            div_op    = 2'b01;
            operand_a = $urandom;
            operand_b = $urandom | 32'd1;
            tick();
        end
        req_valid = 1'b0;
        wait_idle();

        // Reset in CALC cycle 20
        issue(2'b00, $urandom, 32'd7);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Randomized operations with occasional flushes
        for (int i = 0; i < 60; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
            issue(2'($urandom), rand_opnd(), rand_opnd());
            repeat ($urandom_range(0, 40)) tick();
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            wait_idle();
        end

        repeat (5) tick();
        if (sb_q.size() != 0) flag_fail("responses outstanding at end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, in the execute stage of the 5-stage pipeline beside the single-cycle ALU. The ALU finishes every operation in one cycle. This block takes a request through a valid/ready handshake, iterates one quotient bit per cycle, and returns a single-cycle response pulse. The hazard logic stalls the pipeline while `busy` is high. It also drives `flush` on a branch redirect or exception.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two, at least 4.
- `clk`  in  1: the only clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request can be accepted. Equals `(state==IDLE) & ~flush & ~rst`.
- `div_op`  in  2: operation select.
  - 00 = DIV
  - 01 = DIVU
  - 10 = REM
  - 11 = REMU
- `operand_a`  in  WIDTH: dividend.
- `operand_b`  in  WIDTH: divisor.
- `flush`  in  1: abort the operation in flight and discard its result.
- `busy`  out  1: high when state is not IDLE.
- `resp_valid`  out  1: result valid. Pulses for exactly one cycle and has no backpressure.
- `resp_data`  out  WIDTH: quotient or remainder. Registered.

## Operation
- States:
  - IDLE
  - CALC
  - DONE
- Accept: a request is accepted when `req_valid & req_ready`. On acceptance, latch `div_op`, compute sign flags and capture operand magnitudes.
  - Signed ops (DIV, REM): magnitude is the two's-complement absolute value.
  - Unsigned ops: operands are used as is.
  - Clear the remainder register and the iteration counter.
- Special cases are decided at acceptance. They go IDLE→DONE directly and load `resp_data` on the same edge.
  - Divisor == 0: DIV and DIVU return all-ones. REM and REMU return `operand_a`.
  - Signed overflow (DIV or REM, a = 0x80000000, b = 0xFFFFFFFF): DIV returns 0x80000000. REM returns 0.
  - Otherwise the state goes IDLE→CALC.
- CALC performs one restoring step per cycle:
  - Shift {rem, quo} left by 1, bringing in the MSB of the dividend.
  - If rem ≥ |b|, subtract |b| and set the quotient LSB to 1.
  - The counter runs from 0 to WIDTH-1. After the step at count WIDTH-1, go to DONE.
- Sign correction on the CALC→DONE edge, loaded into `resp_data`:
  - Quotient is negated if the signs of a and b differ (signed ops only).
  - Remainder takes the sign of the dividend (signed ops only).
- DONE: `resp_valid = ~flush`. The next state is always IDLE.
- `flush` in any state: the next state is IDLE.
  - `resp_valid` is 0 in the cycle `flush` is high.
  - `req_ready` is 0 in the cycle `flush` is high, so no acceptance occurs in that cycle.
- Reset, including mid-operation: the next state is IDLE, counter 0, `resp_data` 0. Any in-flight operation is dropped with no response.
- All arithmetic is WIDTH+1 bits internally so the compare and subtract never overflow. Results are truncated to WIDTH.

## Timing
- Outputs after reset:
  - `busy` = 0
  - `resp_valid` = 0
  - `resp_data` = 0
  - `req_ready` = 1 from the first cycle with `rst` low
- Normal latency: request accepted in cycle 0, `resp_valid` in cycle WIDTH+1 (33 for WIDTH=32). `busy` is high from cycle 1 through cycle WIDTH+1.
- Special-case latency: accepted in cycle 0, `resp_valid` in cycle 1.
- Throughput: the earliest next acceptance is the cycle after DONE (cycle 34 normal, cycle 2 special).
- Operands are sampled only in the acceptance cycle. Later changes on the inputs have no effect.
- `resp_data` holds its last value until the next DONE load. It is only meaningful while `resp_valid` is high.
- `flush` and `req_valid` high together in IDLE: no acceptance. The request must be re-presented.

## Test plan
- Quotient, DIV 100 / 7: request in cycle 0 → `resp_valid` in cycle 33, `resp_data` = 14. Same inputs with REM → 2.
- Signed corners, dividend -7 (0xFFFFFFF9), divisor 2:
  - DIV → 0xFFFFFFFD (-3).
  - REM → 0xFFFFFFFF (-1).
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Divide by zero, divisor 0, dividend 0x12345678:
  - DIVU → 0xFFFFFFFF in cycle 1.
  - REMU → 0x12345678 in cycle 1.
  - `busy` high for exactly 1 cycle in each case.
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - DIV → 0x80000000 in cycle 1.
  - REM → 0 in cycle 1.
- Flush:
  - Flush in cycle 10 of CALC: no `resp_valid` ever; `busy` is 0 and `req_ready` is 1 in cycle 11. A new DIVU 9 / 3 accepted in cycle 11 returns 3 in cycle 44.
  - Flush in a DONE cycle: `resp_valid` stays 0.
- Back-to-back and reset:
  - `req_valid` held high with changing operands: acceptances occur in cycles 0 and 34 only.
  - `rst` asserted in cycle 20 of CALC: all outputs take their reset values on the next edge, and no stale response appears.
